// File: rtl/button_encoder.sv
// Four-player button encoder: synchronizes and debounces 12 raw buttons,
// accumulates press events per player and offers them round-robin on a valid/ack handshake.
module button_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] btn_in,
  input  logic        ack,
  output logic        valid,
  output logic [2:0]  select,
  output logic [2:0]  buttons,
  output logic        overrun
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [11:0]      sync1_q, sync2_q;
  logic [11:0]      db_q, db_d;
  logic [11:0][7:0] cnt_q, cnt_d;
  logic [3:0][2:0]  pending_q, pending_d;
  logic [3:0][2:0]  rise, clear_mask, kept;
  logic             overrun_q, overrun_d;
  state_t           state_q, state_d;
  logic [2:0]       select_q, select_d;
  logic [2:0]       buttons_q, buttons_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       has_pending;
  logic             grant_found;
  logic [1:0]       grant_p;
  logic [1:0]       cand;

  // Debounce: the counter only runs while the sampled level disagrees with the accepted one.
  always_comb begin
    for (int unsigned i = 0; i < 12; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] + 8'd1 == DB_LIMIT) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise = db_d & ~db_q;

  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      has_pending[p] = |pending_q[p];
    end
    grant_found = 1'b0;
    grant_p     = '0;
    cand        = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      cand = ptr_q + 2'(j);
      if (!grant_found && has_pending[cand]) begin
        grant_found = 1'b1;
        grant_p     = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    buttons_d  = buttons_q;
    ptr_d      = ptr_q;
    clear_mask = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d             = OFFER;
          select_d            = {1'b0, grant_p} + 3'd1;
          buttons_d           = pending_q[grant_p];
          clear_mask[grant_p] = '1;
          ptr_d               = grant_p + 2'd1;
        end
      end
      OFFER: begin
        if (ack) begin
          state_d   = IDLE;
          select_d  = '0;
          buttons_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Events rising on the grant edge survive the clear, so they wait for the next offer.
  always_comb begin
    kept      = pending_q & ~clear_mask;
    pending_d = kept | rise;
    overrun_d = |(kept & rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
      select_q  <= '0;
      buttons_q <= '0;
      ptr_q     <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      select_q  <= select_d;
      buttons_q <= buttons_d;
      ptr_q     <= ptr_d;
    end
  end

  assign valid   = (state_q == OFFER);
  assign select  = select_q;
  assign buttons = buttons_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder at the default debounce length of 4.
module tb_button_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] btn_in = '0;
  logic        ack = 1'b0;
  logic        valid;
  logic [2:0]  select;
  logic [2:0]  buttons;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  button_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .ack     (ack),
    .valid   (valid),
    .select  (select),
    .buttons (buttons),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!valid && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(valid), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      tick();
      if (valid) seen++;
    end
  endtask

  initial begin
    int seen;
    int ovr;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_select", 32'(select), 0);
    check("rst_buttons", 32'(buttons), 0);
    check("rst_overrun", 32'(overrun), 0);
    tick(2);
    rst = 1'b0;

    // Exact latency, hold while ack low
    btn_in = 12'h010;
    tick(6);
    check("lat_pre_valid", 32'(valid), 0);
    tick();
    check("lat_valid", 32'(valid), 1);
    check("lat_select", 32'(select), 2);
    check("lat_buttons", 32'(buttons), 3'b010);
    check("lat_overrun", 32'(overrun), 0);
    tick(3);
    check("hold_valid", 32'(valid), 1);
    check("hold_select", 32'(select), 2);
    check("hold_buttons", 32'(buttons), 3'b010);
    do_ack();
    check("ack_valid", 32'(valid), 0);
    check("ack_select", 32'(select), 0);
    check("ack_buttons", 32'(buttons), 0);
    btn_in = '0;
    count_valid(12, seen);
    check("release_no_offer", 32'(seen), 0);

    // Glitch filtering: 3-cycle pulse rejected, 4-cycle pulse accepted
    btn_in[0] = 1'b1;
    tick(3);
    btn_in[0] = 1'b0;
    count_valid(15, seen);
    check("glitch3_no_offer", 32'(seen), 0);
    btn_in[0] = 1'b1;
    tick(4);
    btn_in[0] = 1'b0;
    wait_valid("pulse4_valid", 15);
    check("pulse4_select", 32'(select), 1);
    check("pulse4_buttons", 32'(buttons), 3'b001);
    do_ack();
    count_valid(12, seen);
    check("pulse4_single", 32'(seen), 0);

    // Round-robin between players 0 and 3 from reset
    @(posedge clk);
    #3 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    btn_in = 12'h201;
    wait_valid("rr1_valid", 15);
    check("rr1_select", 32'(select), 1);
    check("rr1_buttons", 32'(buttons), 3'b001);
    do_ack();
    check("rr1_gap", 32'(valid), 0);
    tick();
    check("rr2_valid", 32'(valid), 1);
    check("rr2_select", 32'(select), 4);
    check("rr2_buttons", 32'(buttons), 3'b001);
    do_ack();
    btn_in = '0;
    tick(12);
    btn_in = 12'h201;
    wait_valid("rr3_valid", 15);
    check("rr3_select", 32'(select), 1);
    do_ack();
    check("rr3_gap", 32'(valid), 0);
    tick();
    check("rr4_select", 32'(select), 4);
    do_ack();
    btn_in = '0;
    tick(12);

    // Staggered presses of player 1 accumulate while another offer is held
    btn_in[0] = 1'b1;
    wait_valid("acc_p0_valid", 15);
    check("acc_p0_select", 32'(select), 1);
    btn_in[3] = 1'b1;
    tick(3);
    btn_in[5] = 1'b1;
    tick(12);
    check("acc_hold_select", 32'(select), 1);
    do_ack();
    check("acc_gap", 32'(valid), 0);
    tick();
    check("acc_valid", 32'(valid), 1);
    check("acc_select", 32'(select), 2);
    check("acc_buttons", 32'(buttons), 3'b101);
    do_ack();
    btn_in = '0;
    count_valid(15, seen);
    check("acc_release_no_offer", 32'(seen), 0);

    // Overrun on player 2 while player 3 offer is held
    btn_in[9] = 1'b1;
    wait_valid("ovr_p3_valid", 15);
    check("ovr_p3_select", 32'(select), 4);
    ovr = 0;
    btn_in[7] = 1'b1;
    repeat (10) begin tick(); if (overrun) ovr++; end
    btn_in[7] = 1'b0;
    repeat (10) begin tick(); if (overrun) ovr++; end
    btn_in[7] = 1'b1;
    repeat (12) begin tick(); if (overrun) ovr++; end
    check("ovr_pulses", 32'(ovr), 1);
    do_ack();
    check("ovr_gap", 32'(valid), 0);
    tick();
    check("ovr_select", 32'(select), 3);
    check("ovr_buttons", 32'(buttons), 3'b010);
    do_ack();
    btn_in = '0;
    tick(12);

    // Reset during an offer, button held through reset
    btn_in[0] = 1'b1;
    wait_valid("rstmid_valid", 15);
    check("rstmid_select", 32'(select), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rstmid_valid0", 32'(valid), 0);
    check("rstmid_select0", 32'(select), 0);
    check("rstmid_buttons0", 32'(buttons), 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("rel_pre_valid", 32'(valid), 0);
    tick();
    check("rel_valid", 32'(valid), 1);
    check("rel_select", 32'(select), 1);
    check("rel_buttons", 32'(buttons), 3'b001);
    do_ack();
    btn_in = '0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
